// File: rtl/bp_me_nonsynth_lce_tr_driver.sv
// bp_me_nonsynth_lce_tr_driver: replays trace entries as LCE commands and checks each LCE response
// Ports:
//   clk_i, reset_n_i                     clock, asynchronous active-low reset
//   trace_data_i/trace_v_i/trace_ready_o {last, tr packet, expected_data} input channel
//   tr_pkt_o/tr_pkt_v_o/tr_pkt_yumi_i    command to the LCE
//   tr_pkt_i/tr_pkt_v_i/tr_pkt_ready_o   response from the LCE
//   done_o, error_o, timeout_o, error_count_o  status
module bp_me_nonsynth_lce_tr_driver #(
    parameter int paddr_width_p = 40,
    parameter int dword_width_p = 64,
    parameter int timeout_p = 1024,
    parameter int err_cnt_width_p = 16,
    localparam int tr_width_lp = 5 + paddr_width_p + dword_width_p
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic [tr_width_lp+dword_width_p:0]   trace_data_i,
    input  logic                                 trace_v_i,
    output logic                                 trace_ready_o,
    output logic [tr_width_lp-1:0]               tr_pkt_o,
    output logic                                 tr_pkt_v_o,
    input  logic                                 tr_pkt_yumi_i,
    input  logic [tr_width_lp-1:0]               tr_pkt_i,
    input  logic                                 tr_pkt_v_i,
    output logic                                 tr_pkt_ready_o,
    output logic                                 done_o,
    output logic                                 error_o,
    output logic                                 timeout_o,
    output logic [err_cnt_width_p-1:0]           error_count_o
);
    localparam int cnt_width_lp = (timeout_p > 2) ? $clog2(timeout_p) : 1;
    localparam int d = dword_width_p;
    localparam int w = tr_width_lp;
    typedef enum logic [1:0] {READY, SEND, WAIT, DONE} state_e;
    state_e state, state_n;
    logic [w-1:0] pkt;
    logic [d-1:0] exp_data;
    logic last;
    logic armed;
    logic timeout;
    logic [cnt_width_lp-1:0] cnt;
    logic [err_cnt_width_p-1:0] err_cnt;
    logic accept, sent, resp, expire, mismatch;
    assign accept = (state == READY) && armed && trace_v_i;
    assign sent = (state == SEND) && tr_pkt_yumi_i;
    assign resp = (state == WAIT) && tr_pkt_v_i;
    // Counter reaches timeout_p-1 on this edge; a handshake in the same cycle wins.
    assign expire = ((state == SEND) || (state == WAIT)) && (cnt == cnt_width_lp'(timeout_p - 2)) && !(sent || resp);
    // cmd and uncached compared together; data only for loads (cmd msb clear).
    assign mismatch = (tr_pkt_i[w-1:w-5] != pkt[w-1:w-5])
                   || (tr_pkt_i[w-6:d] != pkt[w-6:d])
                   || (!pkt[w-1] && (tr_pkt_i[d-1:0] != exp_data));
    always_comb begin
        state_n = state;
        case (state)
            READY:   state_n = accept ? SEND : READY;
            SEND:    state_n = expire ? DONE : sent ? WAIT : SEND;
            WAIT:    state_n = expire ? DONE : resp ? (last ? DONE : READY) : WAIT;
            default: state_n = DONE;
        endcase
    end
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= READY;
            armed <= 1'b0;
            pkt <= '0;
            exp_data <= '0;
            last <= 1'b0;
            cnt <= '0;
            timeout <= 1'b0;
            err_cnt <= '0;
        end else begin
            state <= state_n;
            armed <= 1'b1;
            if (accept) begin
                {last, pkt, exp_data} <= trace_data_i;
                cnt <= '0;
            end else if ((state == SEND) || (state == WAIT)) begin
                cnt <= cnt + 1'b1;
            end
            if (expire)
                timeout <= 1'b1;
            if (resp && mismatch && !(&err_cnt))
                err_cnt <= err_cnt + 1'b1;
        end
    end
    // armed keeps trace_ready_o low while reset is held.
    assign trace_ready_o = (state == READY) && armed;
    assign tr_pkt_o = pkt;
    assign tr_pkt_v_o = (state == SEND);
    assign tr_pkt_ready_o = (state == WAIT);
    assign done_o = (state == DONE);
    assign timeout_o = timeout;
    assign error_count_o = err_cnt;
    assign error_o = (err_cnt != '0) || timeout;
endmodule
